// File: rtl/bp_me_pkg.sv
// Shared types and mem NoC header field layout for the I/O forward-path deserializer.
package bp_me_pkg;

   localparam int mem_noc_len_lsb_lp   = 0;
   localparam int mem_noc_len_width_lp = 4;

   typedef enum logic [1:0] {
      e_header = 2'b00,
      e_body   = 2'b01,
      e_out    = 2'b10
   } bp_io_deser_state_e;

endpackage

// File: rtl/bp_io_fwd_wormhole_deserializer.sv
// Reassembles wormhole packets (header + len body flits) from the mem-forward edge
// into one wide zero-padded packet word; flags packets longer than the buffer.
//
// state    | meaning
// e_header | waiting for a header flit; clears buffer and latches len
// e_body   | collecting body flits until len have been taken
// e_out    | packet presented on packet_o until the consumer accepts it
module bp_io_fwd_wormhole_deserializer
   import bp_me_pkg::*;
#(
   parameter int flit_width_p = 64,
   parameter int len_width_p  = mem_noc_len_width_lp,
   parameter int len_lsb_p    = mem_noc_len_lsb_lp,
   parameter int max_len_p    = 8
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [flit_width_p-1:0]              link_data_i,
   input  logic                                 link_v_i,
   output logic                                 link_ready_and_o,
   output logic [flit_width_p*(max_len_p+1)-1:0] packet_o,
   output logic [len_width_p-1:0]               packet_len_o,
   output logic                                 packet_v_o,
   input  logic                                 packet_ready_and_i,
   output logic                                 overflow_o
);

   localparam logic [len_width_p-1:0] one_lp = len_width_p'(1);

   bp_io_deser_state_e          state_q, state_d;
   logic [len_width_p-1:0]      count_q, count_d;
   logic [len_width_p-1:0]      len_q, len_d;
   logic                        overflow_q, overflow_d;
   logic                        rdy_en_q, rdy_en_d;
   logic [flit_width_p-1:0]     buf_q [max_len_p+1];
   logic [flit_width_p-1:0]     buf_d [max_len_p+1];

   // Ready is held off until the first clock after reset release.
   assign rdy_en_d = 1'b1;

   always_comb begin
      state_d          = state_q;
      count_d          = count_q;
      len_d            = len_q;
      overflow_d       = overflow_q;
      buf_d            = buf_q;
      link_ready_and_o = 1'b0;
      packet_v_o       = 1'b0;

      case (state_q)
         e_header: begin
            link_ready_and_o = rdy_en_q;
            if (link_v_i && rdy_en_q) begin
               for (int k = 0; k <= max_len_p; k++) buf_d[k] = '0;
               buf_d[0] = link_data_i;
               len_d    = link_data_i[len_lsb_p +: len_width_p];
               count_d  = '0;
               state_d  = (len_d == '0) ? e_out : e_body;
            end
         end
         e_body: begin
            link_ready_and_o = rdy_en_q;
            if (link_v_i && rdy_en_q) begin
               // Flits past the buffer depth are dropped but still counted.
               for (int k = 1; k <= max_len_p; k++) begin
                  if (int'(count_q) == k - 1) buf_d[k] = link_data_i;
               end
               if (int'(count_q) >= max_len_p) overflow_d = 1'b1;
               count_d = count_q + one_lp;
               if (count_q == len_q - one_lp) state_d = e_out;
            end
         end
         e_out: begin
            packet_v_o = 1'b1;
            if (packet_ready_and_i) state_d = e_header;
         end
         default: state_d = e_header;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= e_header;
         count_q    <= '0;
         len_q      <= '0;
         overflow_q <= 1'b0;
         rdy_en_q   <= 1'b0;
         for (int k = 0; k <= max_len_p; k++) buf_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         len_q      <= len_d;
         overflow_q <= overflow_d;
         rdy_en_q   <= rdy_en_d;
         for (int k = 0; k <= max_len_p; k++) buf_q[k] <= buf_d[k];
      end
   end

   always_comb begin
      packet_o = '0;
      for (int k = 0; k <= max_len_p; k++) begin
         packet_o[k*flit_width_p +: flit_width_p] = buf_q[k];
      end
   end

   assign packet_len_o = len_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_bp_io_fwd_wormhole_deserializer.sv
// Self-checking bench: directed packet table, reset-abort sequence, random packets vs model.
module tb_bp_io_fwd_wormhole_deserializer;

   localparam int W  = 64;
   localparam int L  = 4;
   localparam int M  = 8;
   localparam int PW = W * (M + 1);

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [W-1:0]  link_data_i;
   logic          link_v_i;
   logic          link_ready_and_o;
   logic [PW-1:0] packet_o;
   logic [L-1:0]  packet_len_o;
   logic          packet_v_o;
   logic          packet_ready_and_i;
   logic          overflow_o;

   bp_io_fwd_wormhole_deserializer #(
      .flit_width_p(W), .len_width_p(L), .len_lsb_p(0), .max_len_p(M)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .link_data_i(link_data_i), .link_v_i(link_v_i), .link_ready_and_o(link_ready_and_o),
      .packet_o(packet_o), .packet_len_o(packet_len_o), .packet_v_o(packet_v_o),
      .packet_ready_and_i(packet_ready_and_i), .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] body_a [16];

   typedef struct {
      logic [W-1:0] hdr;
      logic [W-1:0] body_base;
      int           gap;
      int           rdy_dly;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: header in slot 0, first min(len,M) body flits in slots 1.., rest zero.
   function automatic logic [PW-1:0] model_pkt(input logic [W-1:0] hdr);
      logic [PW-1:0] p;
      int len;
      p   = '0;
      len = int'(hdr[L-1:0]);
      p[W-1:0] = hdr;
      for (int i = 0; i < len && i < M; i++) p[(i+1)*W +: W] = body_a[i];
      return p;
   endfunction

   // Called just after a posedge; returns just after the transfer edge.
   task automatic send_flit(input logic [W-1:0] d, input int gap);
      logic ok;
      ok = 1'b0;
      repeat (gap) begin @(posedge clk_i); #1; end
      link_data_i = d;
      link_v_i    = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk_i);
         if (link_ready_and_o) begin ok = 1'b1; break; end
      end
      @(posedge clk_i); #1;
      link_v_i    = 1'b0;
      link_data_i = 'x;
      if (!ok) begin checks++; errors++; $display("FAIL flit_timeout: ready never seen, expected 1"); end
   endtask

   task automatic recv(input string nm, input logic [PW-1:0] exp_pkt, input logic [L-1:0] exp_len,
                       input logic exp_ovf, input int rdy_dly);
      logic seen;
      seen = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (packet_v_o) begin seen = 1'b1; break; end
         @(negedge clk_i);
      end
      chk({nm, "_valid"}, PW'(seen), PW'(1'b1));
      chk({nm, "_pkt"}, packet_o, exp_pkt);
      chk({nm, "_len"}, PW'(packet_len_o), PW'(exp_len));
      chk({nm, "_ovf"}, PW'(overflow_o), PW'(exp_ovf));
      chk({nm, "_rdy_low"}, PW'(link_ready_and_o), PW'(1'b0));
      repeat (rdy_dly) @(negedge clk_i);
      if (rdy_dly > 0) begin
         chk({nm, "_stable_pkt"}, packet_o, exp_pkt);
         chk({nm, "_stable_v"}, PW'(packet_v_o), PW'(1'b1));
      end
      packet_ready_and_i = 1'b1;
      @(posedge clk_i); #1;
      packet_ready_and_i = 1'b0;
      @(negedge clk_i);
      chk({nm, "_next_rdy"}, PW'(link_ready_and_o), PW'(1'b1));
      chk({nm, "_v_drop"}, PW'(packet_v_o), PW'(1'b0));
      @(posedge clk_i); #1;
   endtask

   task automatic run_packet(input string nm, input logic [W-1:0] hdr, input int gap,
                             input int rdy_dly, input logic exp_ovf);
      int len;
      len = int'(hdr[L-1:0]);
      send_flit(hdr, gap);
      for (int i = 0; i < len; i++) send_flit(body_a[i], gap);
      @(negedge clk_i);
      chk({nm, "_latency"}, PW'(packet_v_o), PW'(1'b1));
      recv(nm, model_pkt(hdr), hdr[L-1:0], exp_ovf, rdy_dly);
   endtask

   initial begin
      reset_i            = 1'b1;
      link_v_i           = 1'b0;
      link_data_i        = '0;
      packet_ready_and_i = 1'b0;

      vecs[0] = '{64'h0000_0000_0000_0A50, 64'h0,                  0, 0,  1'b0};
      vecs[1] = '{64'hC0DE_0000_0000_0003, 64'h11,                 0, 0,  1'b0};
      vecs[2] = '{64'h2222_0000_0000_0002, 64'h0101_0101_0101_0101, 5, 10, 1'b0};
      vecs[3] = '{64'hBEEF_0000_0000_000A, 64'h1000_0000_0000_0001, 0, 1,  1'b1};
      vecs[4] = '{64'h5A5A_0000_0000_0001, 64'h77,                 1, 2,  1'b1};

      #12;
      chk("rst_v", PW'(packet_v_o), '0);
      chk("rst_len", PW'(packet_len_o), '0);
      chk("rst_ovf", PW'(overflow_o), '0);
      chk("rst_pkt", packet_o, '0);
      chk("rst_rdy", PW'(link_ready_and_o), '0);
      @(negedge clk_i);
      reset_i = 1'b0;
      @(posedge clk_i); @(posedge clk_i); #1;
      chk("post_rst_rdy", PW'(link_ready_and_o), PW'(1'b1));

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < int'(vecs[v].hdr[L-1:0]); i++)
            body_a[i] = vecs[v].body_base * 64'(i + 1);
         run_packet($sformatf("vec%0d", v), vecs[v].hdr, vecs[v].gap, vecs[v].rdy_dly, vecs[v].exp_ovf);
      end

      // Reset in the middle of a len=4 packet, after two body flits.
      body_a[0] = 64'hDEAD_0001;
      body_a[1] = 64'hDEAD_0002;
      send_flit(64'hFFFF_0000_0000_0004, 0);
      send_flit(body_a[0], 0);
      send_flit(body_a[1], 0);
      #2 reset_i = 1'b1;
      #1;
      chk("mid_rst_pkt", packet_o, '0);
      chk("mid_rst_len", PW'(packet_len_o), '0);
      chk("mid_rst_ovf", PW'(overflow_o), '0);
      chk("mid_rst_v", PW'(packet_v_o), '0);
      @(negedge clk_i);
      reset_i = 1'b0;
      @(posedge clk_i); @(posedge clk_i); #1;
      body_a[0] = 64'h4242_4242;
      run_packet("after_rst", 64'h0123_0000_0000_0001, 0, 0, 1'b0);

      for (int p = 0; p < 100; p++) begin
         logic [W-1:0] hdr;
         int len;
         len = $urandom_range(0, M);
         hdr = {$urandom, $urandom};
         hdr[L-1:0] = L'(len);
         for (int i = 0; i < len; i++) body_a[i] = {$urandom, $urandom};
         run_packet($sformatf("rnd%0d", p), hdr, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

endmodule
